// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg: shared types and default widths for the ROM stream reader.
//   DEF_ADDR_W / DEF_DATA_W : default ROM address / word widths
//   state_t                 : sequencer state (IDLE, RUN, DRAIN)
//   beat_t                  : one buffered output word plus its last-beat tag
package rom_reader_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
    } beat_t;

endpackage

// File: rtl/rom_reader_fifo.sv
// rom_reader_fifo: small synchronous FIFO of beat_t entries.
//   clk, rst   : clock, synchronous active-high reset (also clears storage)
//   push       : write push_beat (ignored when full and not popping)
//   push_beat  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry
//   not_empty  : at least one entry stored
//   count      : number of stored entries
module rom_reader_fifo
    import rom_reader_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  beat_t            push_beat,
    input  logic             pop,
    output beat_t            head,
    output logic             not_empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    beat_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: address sequencer and response collector in front of a
// synchronous ROM. A command walks len consecutive addresses from start_addr
// (wrapping), and the returned words are streamed out with valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   start, start_addr,
//   len                 : command strobe (taken in IDLE only), first address,
//                         word count 0..2**ADDR_W
//   busy, done          : command in progress / one-cycle completion pulse
//   rom_en, rom_addr    : registered ROM read request
//   rom_data            : ROM word, valid the cycle after rom_en
//   out_valid, out_ready,
//   out_data, out_last  : output stream, out_last on the final word
//   stall_cnt           : cycles with out_valid & !out_ready, saturating at 255;
//                         present only when ROM_READER_PERF_EN is defined,
//                         otherwise tied to zero
module rom_stream_reader
    import rom_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [7:0]        stall_cnt
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t            state;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W:0]   remaining;
    logic              rom_last;
    logic              rsp_pend;
    logic              rsp_last;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W+1:0]  used;
    logic              credit_ok;
    logic              pop;
    beat_t             head;
    beat_t             push_beat;

    // Entries already buffered plus reads still travelling through the ROM;
    // a read may only be issued if its word is guaranteed a FIFO slot. The
    // pop happening this cycle is deliberately not counted as a free slot.
    assign used      = (CNT_W+2)'(fifo_count) + (CNT_W+2)'(rom_en) + (CNT_W+2)'(rsp_pend);
    assign credit_ok = (used <= (CNT_W+2)'(FIFO_DEPTH - 1));

    assign pop       = out_valid && out_ready;
    assign push_beat = '{data: rom_data, last: rsp_last};
    assign out_data  = head.data;
    assign out_last  = head.last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            rom_last  <= 1'b0;
            next_addr <= '0;
            remaining <= '0;
            rsp_pend  <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rsp_pend <= rom_en;
            rsp_last <= rom_last;
            case (state)
                IDLE: begin
                    rom_en <= 1'b0;
                    if (start) begin
                        if (len != '0) begin
                            // The first read goes out on the accepting edge so
                            // rom_en is already high in the first busy cycle;
                            // the FIFO is empty and nothing is in flight here.
                            busy      <= 1'b1;
                            rom_en    <= 1'b1;
                            rom_addr  <= start_addr;
                            next_addr <= start_addr + ADDR_W'(1);
                            remaining <= len - (ADDR_W+1)'(1);
                            rom_last  <= (len == (ADDR_W+1)'(1));
                            state     <= (len == (ADDR_W+1)'(1)) ? DRAIN : RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if ((remaining != '0) && credit_ok) begin
                        rom_en    <= 1'b1;
                        rom_addr  <= next_addr;
                        next_addr <= next_addr + ADDR_W'(1);
                        remaining <= remaining - (ADDR_W+1)'(1);
                        rom_last  <= (remaining == (ADDR_W+1)'(1));
                        if (remaining == (ADDR_W+1)'(1)) begin
                            state <= DRAIN;
                        end
                    end else begin
                        rom_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    rom_en <= 1'b0;
                    if (pop && head.last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    rom_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // rom_data is only captured when a response is due; the disabled ROM
    // drives garbage otherwise.
    rom_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_pend),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .not_empty (out_valid),
        .count     (fifo_count)
    );

`ifdef ROM_READER_PERF_EN
    logic [7:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || ((state == IDLE) && start)) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != 8'hFF)) begin
            stall_q <= stall_q + 8'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] len;
    logic       busy;
    logic       done;
    logic       rom_en;
    logic [3:0] rom_addr;
    logic [3:0] rom_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic [7:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Activity observed by the bench itself, sampled on the falling edge.
    int         issued;
    int         popped;
    int         max_out;
    int         stalls;
    logic [3:0] addr_q [$];

    logic [3:0] rom [16] = '{4'h2, 4'h2, 4'hE, 4'h2, 4'h4, 4'hA, 4'hC, 4'h0,
                             4'hA, 4'h2, 4'hE, 4'h2, 4'h4, 4'hA, 4'hC, 4'h0};

    always #5 clk = ~clk;

    // Synchronous ROM; 5 (not a stored word) is driven while disabled.
    always @(posedge clk) rom_data <= rom_en ? rom[rom_addr] : 4'h5;

    rom_stream_reader #(
        .ADDR_W     (4),
        .DATA_W     (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .stall_cnt  (stall_cnt)
    );

    task automatic tick();
        @(negedge clk);
        if (rom_en) begin
            issued++;
            addr_q.push_back(rom_addr);
        end
        if (issued - popped > max_out) max_out = issued - popped;
        if (out_valid && out_ready) popped++;
        if (out_valid && !out_ready) stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [3:0] a, input logic [4:0] n);
        start      = 1'b1;
        start_addr = a;
        len        = n;
        issued     = 0;
        popped     = 0;
        max_out    = 0;
        stalls     = 0;
        addr_q.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, done, rom_en, rom_addr, out_valid, out_data, out_last, stall_cnt} !== 21'h0) begin
            bad++;
            $display("FAIL reset_values: got busy=%b done=%b rom_en=%b rom_addr=%h valid=%b data=%h last=%b stall=%0d want all zero",
                     busy, done, rom_en, rom_addr, out_valid, out_data, out_last, stall_cnt);
        end
        rst = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || rom_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b valid=%b rom_en=%b want 0 0 0", busy, out_valid, rom_en);
        end
    endtask

    task automatic test_basic();
        logic [3:0] want [4] = '{4'hE, 4'h2, 4'h4, 4'hA};
        int got = 0, n_done = 0, c_first = -1, c_last = -1;
        bit fin = 0, hs_last_prev = 0;
        out_ready = 1'b1;
        start_cmd(4'd2, 5'd4);
        total++;
        if (busy !== 1'b1 || rom_en !== 1'b1 || rom_addr !== 4'd2) begin
            bad++;
            $display("FAIL basic_issue: got busy=%b rom_en=%b rom_addr=%0d want 1 1 2", busy, rom_en, rom_addr);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_valid: got valid=%b want 0", out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_latency: got valid=%b want 1 three cycles after start", out_valid);
        end
        for (int c = 0; c < 40 && !fin; c++) begin
            if (done) begin
                n_done++;
                fin = 1;
                total++;
                if (!hs_last_prev || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_done: got lasths_prev=%b busy=%b want 1 0", hs_last_prev, busy);
                end
            end
            hs_last_prev = 0;
            if (out_valid && out_ready) begin
                total++;
                if (got >= 4 || out_data !== want[got] || out_last !== (got == 3)) begin
                    bad++;
                    $display("FAIL basic_beat%0d: got data=%h last=%b want data=%h last=%b",
                             got, out_data, out_last, want[got], (got == 3));
                end
                if (c_first < 0) c_first = c;
                c_last = c;
                hs_last_prev = out_last;
                got++;
            end
            if (!fin) tick();
        end
        total++;
        if (got !== 4 || n_done !== 1 || (c_last - c_first) !== 3) begin
            bad++;
            $display("FAIL basic_summary: got beats=%0d dones=%0d span=%0d want 4 1 3", got, n_done, c_last - c_first);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_after_done: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] want [4] = '{4'hC, 4'h0, 4'h2, 4'h2};
        logic [15:0] seq;
        int got = 0, n_done = 0;
        bit fin = 0;
        out_ready = 1'b1;
        start_cmd(4'd14, 5'd4);
        for (int c = 0; c < 40 && !fin; c++) begin
            if (done) begin
                n_done++;
                fin = 1;
            end
            if (out_valid && out_ready) begin
                total++;
                if (got >= 4 || out_data !== want[got] || out_last !== (got == 3)) begin
                    bad++;
                    $display("FAIL wrap_beat%0d: got data=%h last=%b want data=%h last=%b",
                             got, out_data, out_last, want[got], (got == 3));
                end
                got++;
            end
            if (!fin) tick();
        end
        seq = (addr_q.size() == 4) ? {addr_q[0], addr_q[1], addr_q[2], addr_q[3]} : 16'hxxxx;
        total++;
        if (seq !== 16'hEF01) begin
            bad++;
            $display("FAIL wrap_addr_seq: got %h (%0d reads) want ef01", seq, addr_q.size());
        end
        total++;
        if (got !== 4 || n_done !== 1) begin
            bad++;
            $display("FAIL wrap_summary: got beats=%0d dones=%0d want 4 1", got, n_done);
        end
    endtask

    task automatic test_zero_len();
        bit any_valid = 0;
        out_ready = 1'b1;
        start_cmd(4'd3, 5'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || rom_en !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_done: got done=%b busy=%b rom_en=%b want 1 0 0", done, busy, rom_en);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_pulse: got done=%b want 0", done);
        end
        for (int c = 0; c < 4; c++) begin
            if (out_valid) any_valid = 1;
            tick();
        end
        total++;
        if (issued !== 0 || any_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_quiet: got reads=%0d valid_seen=%b want 0 0", issued, any_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] want [8] = '{4'h2, 4'h2, 4'hE, 4'h2, 4'h4, 4'hA, 4'hC, 4'h0};
        int got = 0, n_done = 0;
        bit fin = 0, hold_ok = 1;
        out_ready = 1'b0;
        start_cmd(4'd0, 5'd8);
        for (int c = 0; c < 12; c++) begin
            if (c >= 2 && (out_valid !== 1'b1 || out_data !== 4'h2 || out_last !== 1'b0)) hold_ok = 0;
            tick();
        end
        total++;
        if (hold_ok !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold: got unstable head, now valid=%b data=%h want valid=1 data=2", out_valid, out_data);
        end
        total++;
        if (issued !== 4 || rom_en !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_credit: got reads=%0d rom_en=%b busy=%b want 4 0 1", issued, rom_en, busy);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 60 && !fin; c++) begin
            if (done) begin
                n_done++;
                fin = 1;
            end
            if (out_valid && out_ready) begin
                total++;
                if (got >= 8 || out_data !== want[got] || out_last !== (got == 7)) begin
                    bad++;
                    $display("FAIL bp_beat%0d: got data=%h last=%b want data=%h last=%b",
                             got, out_data, out_last, want[got], (got == 7));
                end
                got++;
            end
            if (!fin) tick();
        end
        total++;
        if (got !== 8 || n_done !== 1 || issued !== 8 || max_out > 4) begin
            bad++;
            $display("FAIL bp_summary: got beats=%0d dones=%0d reads=%0d max_out=%0d want 8 1 8 <=4",
                     got, n_done, issued, max_out);
        end
    endtask

    task automatic test_stream();
        logic [3:0] want [16] = '{4'hA, 4'hC, 4'h0, 4'hA, 4'h2, 4'hE, 4'h2, 4'h4,
                                  4'hA, 4'hC, 4'h0, 4'h2, 4'h2, 4'hE, 4'h2, 4'h4};
        logic [7:0] want_stall;
        int got = 0, n_done = 0;
        bit fin = 0;
        out_ready = 1'b0;
        start_cmd(4'd5, 5'd16);
        for (int c = 0; c < 200 && !fin; c++) begin
            out_ready = ((c % 2) == 1);
            if (done) begin
                n_done++;
                fin = 1;
            end
            if (out_valid && out_ready) begin
                total++;
                if (got >= 16 || out_data !== want[got] || out_last !== (got == 15)) begin
                    bad++;
                    $display("FAIL stream_beat%0d: got data=%h last=%b want data=%h last=%b",
                             got, out_data, out_last, want[got], (got == 15));
                end
                got++;
            end
            if (!fin) tick();
        end
        total++;
        if (got !== 16 || n_done !== 1 || max_out > 4) begin
            bad++;
            $display("FAIL stream_summary: got beats=%0d dones=%0d max_out=%0d want 16 1 <=4", got, n_done, max_out);
        end
`ifdef ROM_READER_PERF_EN
        want_stall = (stalls > 255) ? 8'd255 : 8'(stalls);
`else
        want_stall = 8'd0;
`endif
        total++;
        if (stall_cnt !== want_stall) begin
            bad++;
            $display("FAIL stream_stall_cnt: got %0d want %0d", stall_cnt, want_stall);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] want [4] = '{4'hE, 4'h2, 4'h4, 4'hA};
        int got = 0, n_done = 0;
        bit fin = 0, quiet = 1;
        out_ready = 1'b1;
        start_cmd(4'd0, 5'd16);
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++;
        if ({busy, done, rom_en, rom_addr, out_valid, out_data, out_last, stall_cnt} !== 21'h0) begin
            bad++;
            $display("FAIL midrst_values: got busy=%b done=%b rom_en=%b rom_addr=%h valid=%b data=%h last=%b stall=%0d want all zero",
                     busy, done, rom_en, rom_addr, out_valid, out_data, out_last, stall_cnt);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done || out_valid || busy || rom_en) quiet = 0;
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++;
            $display("FAIL midrst_quiet: got activity after reset (done=%b valid=%b) want none", done, out_valid);
        end
        start_cmd(4'd2, 5'd4);
        for (int c = 0; c < 40 && !fin; c++) begin
            if (done) begin
                n_done++;
                fin = 1;
            end
            if (out_valid && out_ready) begin
                total++;
                if (got >= 4 || out_data !== want[got] || out_last !== (got == 3)) begin
                    bad++;
                    $display("FAIL midrst_beat%0d: got data=%h last=%b want data=%h last=%b",
                             got, out_data, out_last, want[got], (got == 3));
                end
                got++;
            end
            if (!fin) tick();
        end
        total++;
        if (got !== 4 || n_done !== 1) begin
            bad++;
            $display("FAIL midrst_restart: got beats=%0d dones=%0d want 4 1", got, n_done);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        out_ready  = 1'b0;
        issued     = 0;
        popped     = 0;
        max_out    = 0;
        stalls     = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_backpressure();
        test_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
